video_stream_sink: RTL

- Receiving end of the 24-bit RGB pixel stream the fractal pipeline produces (tdata packed {r,g,b}, zeroed when invalid).
- Accepts AXI4-Stream video beats with backpressure and unpacks each beat into r/g/b plus pixel coordinates.
- Checks frame geometry against SOF (tuser) and EOL (tlast) markers, counts errors and completed frames.
- Sits between the stream generator and the display/capture logic or testbench scoreboard.

---
 rtl/video_stream_sink.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/video_stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : video_stream_sink
// Purpose  : AXI4-Stream RGB video sink. Unpacks {r,g,b} beats, tracks pixel
//            coordinates, checks frame geometry against SOF (tuser) and
//            EOL (tlast) markers, and counts frames and marker errors.
// Revision : 1.0 - initial release
// ============================================================================
module video_stream_sink #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480,
  parameter int CW     = 11
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [23:0]   s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tuser,
  input  logic          s_axis_tlast,
  input  logic          sink_stall,
  output logic          pix_valid,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic [7:0]    err_sof,
  output logic [7:0]    err_eol
);

  localparam logic [CW-1:0] X_LAST = CW'(X_SIZE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    WAIT_SOF  = 2'd0,
    ACTIVE    = 2'd1,
    DROP_LINE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] x, x_nx, y, y_nx;
  logic          xfer;
  logic          emit;
  logic [CW-1:0] emit_x, emit_y;
  logic          sof_err, eol_err, line_end, frame_end;

  // Ready only depends on reset and downstream stall; no internal buffering.
  assign s_axis_tready = !areset && !sink_stall;
  assign xfer          = s_axis_tvalid && s_axis_tready;

  // Next-state, coordinate update and event decode for one transferred beat.
  always_comb begin
    state_nx  = state;
    x_nx      = x;
    y_nx      = y;
    emit      = 1'b0;
    emit_x    = x;
    emit_y    = y;
    sof_err   = 1'b0;
    eol_err   = 1'b0;
    line_end  = 1'b0;
    frame_end = 1'b0;
    if (xfer) begin
      if (s_axis_tuser) begin
        // SOF always restarts the frame; outside WAIT_SOF it abandons one.
        sof_err  = (state != WAIT_SOF);
        emit     = 1'b1;
        emit_x   = '0;
        emit_y   = '0;
        x_nx     = CW'(1);
        y_nx     = '0;
        state_nx = ACTIVE;
      end else begin
        case (state)
          WAIT_SOF: sof_err = 1'b1;
          ACTIVE: begin
            emit = 1'b1;
            if (x == X_LAST) begin
              if (s_axis_tlast) begin
                line_end = 1'b1;
              end else begin
                eol_err  = 1'b1;
                state_nx = DROP_LINE;
              end
            end else if (s_axis_tlast) begin
              eol_err  = 1'b1;
              line_end = 1'b1;
            end else begin
              x_nx = x + CW'(1);
            end
          end
          DROP_LINE: line_end = s_axis_tlast;
          default:   state_nx = WAIT_SOF;
        endcase
        // Line termination (normal, early, or end of a dropped line).
        if (line_end) begin
          x_nx = '0;
          if (y == Y_LAST) begin
            y_nx      = '0;
            frame_end = 1'b1;
            state_nx  = WAIT_SOF;
          end else begin
            y_nx     = y + CW'(1);
            state_nx = ACTIVE;
          end
        end
      end
    end
  end

  // State, coordinate, pixel output and counter registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= WAIT_SOF;
      x           <= '0;
      y           <= '0;
      pix_valid   <= 1'b0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_sof     <= '0;
      err_eol     <= '0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      pix_valid  <= emit;
      frame_done <= frame_end;
      if (emit) begin
        pix_r <= s_axis_tdata[23:16];
        pix_g <= s_axis_tdata[15:8];
        pix_b <= s_axis_tdata[7:0];
        pix_x <= emit_x;
        pix_y <= emit_y;
      end
      if (frame_end) frame_count <= frame_count + 16'd1;
      if (sof_err && (err_sof != 8'hFF)) err_sof <= err_sof + 8'd1;
      if (eol_err && (err_eol != 8'hFF)) err_eol <= err_eol + 8'd1;
    end
  end

endmodule
`default_nettype wire
